// File: rtl/ifu_prefetch.sv
// Instruction fetch unit: owns the fetch PC, keeps one read outstanding and
// buffers returned words in a DEPTH-entry FIFO that feeds the IDU.
module ifu_prefetch #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h80000000),
  parameter int                DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              idu_valid,
  input  logic              idu_ready,
  output logic [DATA_W-1:0] idu_inst,
  output logic [ADDR_W-1:0] idu_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_STALL} state_t;

  state_t            state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] req_pc;
  logic              drop;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [DATA_W-1:0] inst_mem [DEPTH];

  logic              accept;
  logic              resp;
  logic              push;
  logic              pop;
  logic              room;
  logic [ADDR_W-1:0] redirect_aligned;

  assign redirect_aligned = redirect_pc & ~ADDR_W'(3);

  assign accept = (state == S_REQ) && mem_req_ready;
  assign resp   = (state == S_WAIT) && mem_resp_valid;
  // Redirect wins over push: a word arriving with a redirect belongs to the old stream.
  assign push   = resp && !drop && !redirect_valid;
  assign pop    = idu_valid && idu_ready;

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + CNT_W'(1);
    end else if (pop && !push) begin
      count_next = count - CNT_W'(1);
    end
  end

  // Credit check only looks at the post-update occupancy, so idu_ready reaches
  // the request side solely through this comparison and the state register.
  assign room = (count_next < DEPTH_C);

  assign mem_req_valid = (state == S_REQ);
  assign mem_req_addr  = fetch_pc;
  assign idu_valid     = (count != '0);
  assign idu_inst      = idu_valid ? inst_mem[rd_ptr] : '0;
  assign idu_pc        = idu_valid ? pc_mem[rd_ptr]   : '0;

  // Control: fetch state machine, PC and FIFO bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_REQ;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      drop     <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      fetch_pc <= redirect_aligned;
      case (state)
        S_REQ: begin
          if (accept) begin
            state <= S_WAIT;
            drop  <= 1'b1;
          end
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            state <= S_REQ;
            drop  <= 1'b0;
          end else begin
            drop  <= 1'b1;
          end
        end
        default: state <= S_REQ;
      endcase
    end else begin
      count <= count_next;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case (state)
        S_REQ: begin
          if (accept) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + ADDR_W'(4);
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            drop  <= 1'b0;
            state <= room ? S_REQ : S_STALL;
          end
        end
        S_STALL: begin
          if (room) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end

  // Data: FIFO storage, written only on a kept response
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= req_pc;
      inst_mem[wr_ptr] <= mem_resp_data;
    end
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Scoreboard bench for ifu_prefetch: expected fetch stream is queued when a
// stream starts (reset/redirect) and popped on every IDU handshake.
module tb_ifu_prefetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        idu_valid;
  logic        idu_ready;
  logic [31:0] idu_inst;
  logic [31:0] idu_pc;

  ifu_prefetch dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .idu_valid      (idu_valid),
    .idu_ready      (idu_ready),
    .idu_inst       (idu_inst),
    .idu_pc         (idu_pc)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          acc_cnt = 0;
  logic [31:0] exp_q [$];
  logic        auto_mem = 1'b0;
  logic        idu_mode = 1'b0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a == 32'h80000000) ? 32'h00000413 : {a[15:0], ~a[31:16]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load_stream(input logic [31:0] a);
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(a + 32'(4 * i));
  endtask

  // One clock: drive memory model, compare any IDU handshake, advance to edge+1.
  task automatic tick();
    logic        acc;
    logic [31:0] acc_a;
    logic [31:0] e;
    if (auto_mem) begin
      mem_req_ready  = 1'b1;
      mem_resp_valid = pend;
      mem_resp_data  = pend ? inst_of(pend_addr) : 32'h0;
    end
    if (idu_mode) idu_ready = mem_resp_valid;
    #1;
    acc   = mem_req_valid && mem_req_ready;
    acc_a = mem_req_addr;
    if (acc) acc_cnt++;
    if (idu_valid && idu_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_nonempty", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("sb_idu_pc", idu_pc, e);
        chk("sb_idu_inst", idu_inst, inst_of(e));
      end
    end
    if (rst) load_stream(32'h80000000);
    else if (redirect_valid) load_stream({redirect_pc[31:2], 2'b00});
    @(posedge clk);
    #1;
    pend      = auto_mem && acc;
    pend_addr = acc_a;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    idu_ready = 1'b0;
    @(posedge clk); #1;
    tick(); tick();
    chk("rst_idu_valid", 32'(idu_valid), 32'd0);
    chk("rst_idu_inst", idu_inst, 32'h0);
    chk("rst_idu_pc", idu_pc, 32'h0);
    chk("rst_req_valid", 32'(mem_req_valid), 32'd1);
    chk("rst_req_addr", mem_req_addr, 32'h80000000);

    // First fetch with 1-cycle memory
    rst = 1'b0; auto_mem = 1'b1; acc_cnt = 0;
    tick();
    chk("wait_req_valid", 32'(mem_req_valid), 32'd0);
    tick();
    chk("first_idu_valid", 32'(idu_valid), 32'd1);
    chk("first_idu_pc", idu_pc, 32'h80000000);
    chk("first_idu_inst", idu_inst, 32'h00000413);
    chk("second_req_addr", mem_req_addr, 32'h80000004);

    // Fill to DEPTH with IDU stalled
    repeat (16) tick();
    chk("full_accepts", 32'(acc_cnt), 32'd4);
    chk("stall_req_valid", 32'(mem_req_valid), 32'd0);
    chk("full_head_pc", idu_pc, 32'h80000000);
    idu_ready = 1'b1; tick(); idu_ready = 1'b0;
    chk("unstall_req_valid", 32'(mem_req_valid), 32'd1);
    chk("unstall_req_addr", mem_req_addr, 32'h80000010);

    // Redirect while a response is arriving in WAIT
    tick(); tick();
    idu_ready = 1'b1; tick(); idu_ready = 1'b0;
    chk("req14_addr", mem_req_addr, 32'h80000014);
    tick();
    chk("req14_wait", 32'(mem_req_valid), 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h80001002;
    tick();
    redirect_valid = 1'b0;
    chk("redir_flush", 32'(idu_valid), 32'd0);
    chk("redir_req_valid", 32'(mem_req_valid), 32'd1);
    chk("redir_req_addr", mem_req_addr, 32'h80001000);
    tick(); tick();
    chk("redir_idu_valid", 32'(idu_valid), 32'd1);
    chk("redir_idu_pc", idu_pc, 32'h80001000);
    chk("redir_next_addr", mem_req_addr, 32'h80001004);

    // Redirect together with request acceptance and an IDU pop
    idu_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80002000;
    tick();
    redirect_valid = 1'b0;
    chk("stale_wait_req", 32'(mem_req_valid), 32'd0);
    chk("stale_idu_valid", 32'(idu_valid), 32'd0);
    tick();
    chk("stale_drop_valid", 32'(idu_valid), 32'd0);
    chk("stale_next_addr", mem_req_addr, 32'h80002000);
    repeat (6) tick();
    chk("s4_req_phase", 32'(mem_req_valid), 32'd1);

    // Address wrap and steady push+pop at count 2
    idu_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFF8;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("wrap_req0", mem_req_addr, 32'hFFFFFFF8);
    tick(); tick(); tick(); tick();
    chk("wrap_req_valid", 32'(mem_req_valid), 32'd1);
    chk("wrap_req_addr", mem_req_addr, 32'h00000000);
    idu_mode = 1'b1;
    repeat (10) tick();
    idu_mode = 1'b0; idu_ready = 1'b0; auto_mem = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    n = 0;
    idu_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (!idu_valid) break;
      tick();
      n++;
    end
    idu_ready = 1'b0;
    chk("steady_count", 32'(n), 32'd2);

    // Reset while WAIT, stale response afterwards
    mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
    chk("pre_rst_wait", 32'(mem_req_valid), 32'd0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("post_rst_req_valid", 32'(mem_req_valid), 32'd1);
    chk("post_rst_req_addr", mem_req_addr, 32'h80000000);
    chk("post_rst_idu_valid", 32'(idu_valid), 32'd0);
    mem_resp_valid = 1'b1; mem_resp_data = 32'hDEADBEEF;
    tick();
    mem_resp_valid = 1'b0;
    chk("stale_resp_ignored", 32'(idu_valid), 32'd0);
    chk("stale_resp_addr", mem_req_addr, 32'h80000000);
    mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = inst_of(32'h80000000);
    tick();
    mem_resp_valid = 1'b0;
    chk("refetch_valid", 32'(idu_valid), 32'd1);
    chk("refetch_pc", idu_pc, 32'h80000000);
    chk("refetch_inst", idu_inst, 32'h00000413);
    idu_ready = 1'b1; tick(); idu_ready = 1'b0;
    chk("final_empty", 32'(idu_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
